// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, index widths, FP16 sign mask and
// helpers for the packed {re, im} twiddle word.
package fft_pkg;

  localparam int LOG2N_DEF = 4;
  localparam int DW_DEF    = 16;
  localparam int STAGE_W   = 2;

  localparam logic [DW_DEF-1:0] FP16_SIGN = 16'h8000;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } tw_state_t;

  function automatic logic [DW_DEF-1:0] tw_re(input logic [2*DW_DEF-1:0] w);
    return w[2*DW_DEF-1:DW_DEF];
  endfunction

  function automatic logic [DW_DEF-1:0] tw_im(input logic [2*DW_DEF-1:0] w);
    return w[DW_DEF-1:0];
  endfunction

endpackage

// File: rtl/twiddle_seq_if.sv
// Twiddle beat stream from the sequencer (master) to the butterfly unit (slave).
interface twiddle_seq_if
  import fft_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF,
  parameter int DW    = DW_DEF
);

  logic                 tw_valid;
  logic                 tw_ready;
  logic [2*DW-1:0]      tw_data;
  logic [STAGE_W-1:0]   tw_stage;
  logic [LOG2N-2:0]     tw_bfly;
  logic                 tw_last;

  modport master (
    output tw_valid, tw_data, tw_stage, tw_bfly, tw_last,
    input  tw_ready
  );

  modport slave (
    input  tw_valid, tw_data, tw_stage, tw_bfly, tw_last,
    output tw_ready
  );

endinterface

// File: rtl/twiddle_seq.sv
// Walks every stage/butterfly of a radix-2 DIT FFT, addresses the external
// twiddle ROM and streams W_N^k (conjugated for IFFT) to the butterfly unit.
module twiddle_seq
  import fft_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              inverse,
  input  logic              abort,
  output logic [LOG2N-2:0]  lut_addr,
  input  logic [2*DW-1:0]   lut_w,
  twiddle_seq_if.master     tw,
  output logic              busy,
  output logic              done
);

  localparam int BW = LOG2N - 1;
  localparam int S  = LOG2N;
  localparam int B  = 1 << (LOG2N - 1);
  localparam logic [2*DW-1:0] CONJ_MASK = (2*DW)'(1) << (DW - 1);

  tw_state_t          state_q, state_d;
  logic               inv_q, inv_d;
  logic [STAGE_W-1:0] s_q, s_d, s_nx;
  logic [BW-1:0]      b_q, b_d, b_nx;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               last_q, last_d;
  logic               done_q, done_d;
  logic [2*DW-1:0]    data_q, data_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [BW-1:0]      bfly_q, bfly_d;
  logic               hs;
  logic               cnt_final;

  // k = (b mod 2^s) << (LOG2N-1-s); the counters already point at the next beat
  always_comb begin
    lut_addr = BW'((32'(b_q) & ((32'd1 << s_q) - 32'd1)) << (32'(BW) - 32'(s_q)));
  end

  always_comb begin
    cnt_final = (s_q == STAGE_W'(S - 1)) && (b_q == BW'(B - 1));
    s_nx      = s_q;
    b_nx      = b_q + 1'b1;
    if (b_q == BW'(B - 1)) begin
      b_nx = '0;
      s_nx = (s_q == STAGE_W'(S - 1)) ? '0 : s_q + 1'b1;
    end
  end

  assign hs = valid_q & tw.tw_ready;

  always_comb begin
    state_d = state_q;
    inv_d   = inv_q;
    s_d     = s_q;
    b_d     = b_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    last_d  = last_q;
    done_d  = 1'b0;
    data_d  = data_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_RUN;
          inv_d   = inverse;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          data_d  = inverse ? (lut_w ^ CONJ_MASK) : lut_w;
          stage_d = s_q;
          bfly_d  = b_q;
          last_d  = cnt_final;
          s_d     = s_nx;
          b_d     = b_nx;
        end
      end
      ST_RUN: begin
        if (abort || (hs && last_q)) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          last_d  = 1'b0;
          s_d     = '0;
          b_d     = '0;
          done_d  = !abort;
        end else if (hs) begin
          data_d  = inv_q ? (lut_w ^ CONJ_MASK) : lut_w;
          stage_d = s_q;
          bfly_d  = b_q;
          last_d  = cnt_final;
          s_d     = s_nx;
          b_d     = b_nx;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      inv_q   <= 1'b0;
      s_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      stage_q <= '0;
      bfly_q  <= '0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
      s_q     <= s_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      done_q  <= done_d;
      data_q  <= data_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
    end
  end

  assign tw.tw_valid = valid_q;
  assign tw.tw_data  = data_q;
  assign tw.tw_stage = stage_q;
  assign tw.tw_bfly  = bfly_q;
  assign tw.tw_last  = last_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
